mem_access_stage: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 22 ++
 rtl/mem_load_align.sv | 26 ++
 rtl/mem_access_stage.sv | 130 +++++++++++++
 tb/tb_mem_access_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM stage: access width/sign encodings and FSM states.
package mips_mem_pkg;

  localparam logic [2:0] OpB  = 3'b000;
  localparam logic [2:0] OpH  = 3'b001;
  localparam logic [2:0] OpW  = 3'b010;
  localparam logic [2:0] OpBu = 3'b100;
  localparam logic [2:0] OpHu = 3'b101;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  // Unknown encodings count as unaligned so they are dropped with the misalign flag.
  function automatic logic op_aligned(logic [2:0] op, logic [1:0] lane);
    case (op)
      OpB, OpBu: op_aligned = 1'b1;
      OpH, OpHu: op_aligned = ~lane[0];
      OpW:       op_aligned = (lane == 2'b00);
      default:   op_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module mem_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  mem_op,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (mem_op)
      OpB:     ext_data = {{24{byte_sel[7]}}, byte_sel};
      OpBu:    ext_data = {24'h0, byte_sel};
      OpH:     ext_data = {{16{half_sel[15]}}, half_sel};
      OpHu:    ext_data = {16'h0, half_sel};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: launches data-memory requests, waits for ready or timeout,
// and holds the pipeline while an access is outstanding.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  mem_op,
  input  logic [31:0] aluresult,
  input  logic [31:0] writedata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] readmemdata,
  output logic        hold,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [CW-1:0] TimeoutCnt = CW'(TIMEOUT);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   result_q;
  logic [2:0]    op_q;
  logic [1:0]    lane_q;

  logic [1:0]    lane;
  logic          rw_ok;
  logic          aligned;
  logic          access;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [31:0]   ext_data;

  always_comb begin
    lane    = aluresult[1:0];
    rw_ok   = memread ^ memwrite;
    aligned = op_aligned(mem_op, lane);
    access  = valid & rw_ok & aligned;
    // Gated by rst_n so every output reads its reset value while reset is held.
    hold     = rst_n & (((state_q == StIdle) & access) | (state_q == StAccess));
    misalign = rst_n & (state_q == StIdle) & valid & (memread | memwrite) & ~(rw_ok & aligned);
    case (mem_op[1:0])
      2'b00: begin
        be_c    = 4'b0001 << lane;
        wdata_c = {4{writedata[7:0]}};
      end
      2'b01: begin
        be_c    = lane[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{writedata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = writedata;
      end
    endcase
  end

  mem_load_align u_load_align (
    .rdata    (dmem_rdata),
    .lane     (lane_q),
    .mem_op   (op_q),
    .ext_data (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      result_q   <= '0;
      op_q       <= '0;
      lane_q     <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      bus_err    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= memwrite;
            dmem_addr  <= {aluresult[31:2], 2'b00};
            dmem_be    <= be_c;
            dmem_wdata <= wdata_c;
            op_q       <= mem_op;
            lane_q     <= lane;
            cnt_q      <= '0;
            state_q    <= StAccess;
          end
        end
        StAccess: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            result_q <= dmem_we ? 32'h0 : ext_data;
            state_q  <= StDone;
          end else if (cnt_q == TimeoutCnt) begin
            dmem_req <= 1'b0;
            result_q <= 32'h0;
            bus_err  <= 1'b1;
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          bus_err <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign readmemdata = result_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table plus timeout and reset sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, memread, memwrite;
  logic [2:0]  mem_op;
  logic [31:0] aluresult, writedata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] readmemdata;
  logic        hold, misalign, bus_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(4), .CW(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (valid),
    .memread     (memread),
    .memwrite    (memwrite),
    .mem_op      (mem_op),
    .aluresult   (aluresult),
    .writedata   (writedata),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_ready  (dmem_ready),
    .dmem_rdata  (dmem_rdata),
    .readmemdata (readmemdata),
    .hold        (hold),
    .misalign    (misalign),
    .bus_err     (bus_err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " req"}, {31'h0, dmem_req}, 32'h0);
    check({tag, " we"}, {31'h0, dmem_we}, 32'h0);
    check({tag, " addr"}, dmem_addr, 32'h0);
    check({tag, " be"}, {28'h0, dmem_be}, 32'h0);
    check({tag, " wdata"}, dmem_wdata, 32'h0);
    check({tag, " rdata"}, readmemdata, 32'h0);
    check({tag, " hold"}, {31'h0, hold}, 32'h0);
    check({tag, " bus_err"}, {31'h0, bus_err}, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int hc;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    valid = 1'b1; memread = v.rd; memwrite = v.wr; mem_op = v.op;
    aluresult = v.addr; writedata = v.wd; dmem_ready = 1'b0;
    #1;
    if (v.exp_mis) begin
      check({tag, " misalign"}, {31'h0, misalign}, 32'h1);
      check({tag, " mis hold"}, {31'h0, hold}, 32'h0);
      @(negedge clk);
      check({tag, " mis req"}, {31'h0, dmem_req}, 32'h0);
      valid = 1'b0;
      #1;
      check({tag, " mis clear"}, {31'h0, misalign}, 32'h0);
      return;
    end
    check({tag, " launch hold"}, {31'h0, hold}, 32'h1);
    check({tag, " launch mis"}, {31'h0, misalign}, 32'h0);
    sb_q.push_back(v.exp_data);
    hc = 1;
    @(negedge clk);
    check({tag, " req"}, {31'h0, dmem_req}, 32'h1);
    check({tag, " we"}, {31'h0, dmem_we}, {31'h0, v.wr});
    check({tag, " addr"}, dmem_addr, {v.addr[31:2], 2'b00});
    check({tag, " be"}, {28'h0, dmem_be}, {28'h0, v.exp_be});
    if (v.wr) check({tag, " wdata"}, dmem_wdata, v.exp_wdata);
    for (int i = 0; i < v.delay; i++) begin
      if (hold) hc++;
      @(negedge clk);
    end
    check({tag, " req held"}, {31'h0, dmem_req}, 32'h1);
    dmem_ready = 1'b1; dmem_rdata = v.rdata;
    #1;
    if (hold) hc++;
    @(negedge clk);
    dmem_ready = 1'b0; dmem_rdata = 32'h5A5A5A5A;
    check({tag, " done hold"}, {31'h0, hold}, 32'h0);
    check({tag, " done req"}, {31'h0, dmem_req}, 32'h0);
    check({tag, " hold cycles"}, hc, v.delay + 2);
    check({tag, " data"}, readmemdata, sb_q.pop_front());
    check({tag, " no bus_err"}, {31'h0, bus_err}, 32'h0);
    valid = 1'b0;
  endtask

  initial begin
    int hc;
    int guard;
    vec_t v;
    //          rd    wr    op      addr          wd            rdata         dly exp_data      be       exp_wdata     mis
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h00000100, 32'h0,       32'hDEADBEEF, 0, 32'hDEADBEEF, 4'b1111, 32'h0,       1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h00000103, 32'h0,       32'h80FF7F01, 1, 32'hFFFFFF80, 4'b1000, 32'h0,       1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h00000103, 32'h0,       32'h80FF7F01, 2, 32'h00000080, 4'b1000, 32'h0,       1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h00000102, 32'h0,       32'h80FF7F01, 0, 32'hFFFF80FF, 4'b1100, 32'h0,       1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h00000100, 32'h0,       32'h80FF7F01, 1, 32'h00007F01, 4'b0011, 32'h0,       1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h00000101, 32'h0,       32'h80FF7F01, 0, 32'h0000007F, 4'b0010, 32'h0,       1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h00000201, 32'h000000AB, 32'h12345678, 0, 32'h0,       4'b0010, 32'hABABABAB, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h00000202, 32'h0000BEEF, 32'h12345678, 3, 32'h0,       4'b1100, 32'hBEEFBEEF, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h00000204, 32'h11223344, 32'h12345678, 1, 32'h0,       4'b1111, 32'h11223344, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'b001, 32'h00000101, 32'h0,       32'h0,       0, 32'h0,       4'b0000, 32'h0,       1'b1};
    vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h00000102, 32'h0,       32'h0,       0, 32'h0,       4'b0000, 32'h0,       1'b1};
    vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h00000100, 32'h0,       32'h0,       0, 32'h0,       4'b0000, 32'h0,       1'b1};

    rst_n = 1'b0; valid = 1'b0; memread = 1'b0; memwrite = 1'b0; mem_op = 3'b000;
    aluresult = 32'h0; writedata = 32'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Nonzero result first so the timeout's zero latch is observable.
    v = '{1'b1, 1'b0, 3'b010, 32'h00000300, 32'h0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 4'b1111, 32'h0,
          1'b0};
    run_vec(v, 12);

    // Timeout: ready withheld.
    @(negedge clk);
    valid = 1'b1; memread = 1'b1; memwrite = 1'b0; mem_op = 3'b010; aluresult = 32'h00000400;
    #1;
    hc = 0;
    guard = 0;
    while (!bus_err && guard < 40) begin
      if (hold) hc++;
      @(negedge clk);
      guard++;
    end
    check("timeout bus_err", {31'h0, bus_err}, 32'h1);
    check("timeout hold cycles", hc, 6);
    check("timeout hold low", {31'h0, hold}, 32'h0);
    check("timeout req low", {31'h0, dmem_req}, 32'h0);
    check("timeout data", readmemdata, 32'h0);
    valid = 1'b0;
    @(negedge clk);
    check("bus_err clears", {31'h0, bus_err}, 32'h0);

    // Reset while an access is outstanding.
    v = '{1'b1, 1'b0, 3'b010, 32'h00000500, 32'h0, 32'h13572468, 0, 32'h13572468, 4'b1111, 32'h0,
          1'b0};
    run_vec(v, 13);
    @(negedge clk);
    valid = 1'b1; memread = 1'b1; mem_op = 3'b010; aluresult = 32'h00000600;
    @(negedge clk);
    check("pre-reset req", {31'h0, dmem_req}, 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async reset");
    check("async reset misalign", {31'h0, misalign}, 32'h0);
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    dmem_ready = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    dmem_ready = 1'b0;
    check("late ready ignored data", readmemdata, 32'h0);
    check("late ready ignored req", {31'h0, dmem_req}, 32'h0);
    check("late ready no hold", {31'h0, hold}, 32'h0);

    check("scoreboard empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
